// File: rtl/potential_adder_if.sv
// Operand and result bundle for the neuron potential update stage.
interface potential_adder_if;
  logic [31:0] v_threshold;
  logic [31:0] input_weight;
  logic [31:0] decayed_potential;
  logic [1:0]  model;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic [31:0] d;
  logic [31:0] u_initialize;
  logic [31:0] final_potential;
  logic        spike;

  modport master (
    output v_threshold, input_weight, decayed_potential, model,
    output a, b, c, d, u_initialize,
    input  final_potential, spike
  );

  modport slave (
    input  v_threshold, input_weight, decayed_potential, model,
    input  a, b, c, d, u_initialize,
    output final_potential, spike
  );
endinterface

// File: rtl/potential_adder.sv
// Membrane potential update: float add of decayed potential and input weight,
// threshold compare and model-dependent reset, registered with one cycle latency.
module potential_adder (
  input  logic              CLK,
  input  logic              clear,
  potential_adder_if.slave  bus
);
  localparam int unsigned FP_W = 32;

  typedef enum logic [1:0] {
    MODEL_LIF  = 2'b00,
    MODEL_IZH  = 2'b01,
    MODEL_SOFT = 2'b10,
    MODEL_ALT  = 2'b11
  } model_e;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic found;
    lzc27 = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        lzc27 = 5'(26 - i);
        found = 1'b1;
      end
    end
  endfunction

  // Single-precision add: denormals flush to signed zero, overflow saturates to infinity, RNE.
  function automatic logic [FP_W-1:0] fp_add(input logic [FP_W-1:0] x, input logic [FP_W-1:0] y);
    logic [31:0]       hi, lo;
    logic [7:0]        diff;
    logic [63:0]       wide;
    logic [26:0]       mx, my, n;
    logic [27:0]       s;
    logic signed [9:0] e;
    logic [4:0]        lz;
    logic [24:0]       m_r;
    logic [22:0]       frac;
    logic              inc;
    if (x[30:0] >= y[30:0]) begin
      hi = x; lo = y;
    end else begin
      hi = y; lo = x;
    end
    fp_add = 32'd0;
    if (hi[30:23] == 8'd0) begin
      fp_add = {hi[31] & lo[31], 31'd0};
    end else if (lo[30:23] == 8'd0) begin
      fp_add = hi;
    end else begin
      diff = hi[30:23] - lo[30:23];
      if (diff > 8'd31) diff = 8'd31;
      wide = {1'b1, lo[22:0], 40'd0} >> diff;
      my   = {wide[63:38], |wide[37:0]};
      mx   = {1'b1, hi[22:0], 3'd0};
      s    = (hi[31] == lo[31]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
      e    = $signed({2'b00, hi[30:23]});
      n    = 27'd0;
      if (s[27]) begin
        n = {s[27:2], s[1] | s[0]};
        e = e + 10'sd1;
      end else begin
        lz = lzc27(s[26:0]);
        n  = s[26:0] << lz;
        e  = e - $signed({5'd0, lz});
      end
      inc = n[2] & (n[1] | n[0] | n[3]);
      m_r = {1'b0, n[26:3]} + 25'(inc);
      if (m_r[24]) begin
        e    = e + 10'sd1;
        frac = m_r[23:1];
      end else begin
        frac = m_r[22:0];
      end
      if (s == 28'd0)             fp_add = 32'd0;
      else if (e >= 10'sd255)     fp_add = {hi[31], 8'hFF, 23'd0};
      else if (e <= 10'sd0)       fp_add = {hi[31], 31'd0};
      else                        fp_add = {hi[31], e[7:0], frac};
    end
  endfunction

  // Signed ordering key; any zero-exponent value maps to zero so +0 == -0.
  function automatic logic signed [32:0] fp_key(input logic [FP_W-1:0] x);
    if (x[30:23] == 8'd0) fp_key = 33'sd0;
    else if (x[31])       fp_key = -$signed({2'b00, x[30:0]});
    else                  fp_key = $signed({2'b00, x[30:0]});
  endfunction

  logic [FP_W-1:0] sum_c, excess_c;
  logic            fire_c;
  logic [FP_W-1:0] final_potential_d, final_potential_q;
  logic            spike_d, spike_q;
  logic            unused_c;

  assign unused_c = ^{bus.a, bus.b, bus.d, bus.u_initialize};

  always_comb begin
    sum_c             = fp_add(bus.decayed_potential, bus.input_weight);
    excess_c          = fp_add(sum_c, {~bus.v_threshold[31], bus.v_threshold[30:0]});
    fire_c            = fp_key(sum_c) >= fp_key(bus.v_threshold);
    final_potential_d = sum_c;
    spike_d           = fire_c;
    if (fire_c) begin
      case (model_e'(bus.model))
        MODEL_IZH:  final_potential_d = bus.c;
        MODEL_SOFT: final_potential_d = excess_c;
        default:    final_potential_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      final_potential_q <= 32'd0;
      spike_q           <= 1'b0;
    end else begin
      final_potential_q <= final_potential_d;
      spike_q           <= spike_d;
    end
  end

  assign bus.final_potential = final_potential_q;
  assign bus.spike           = spike_q;
endmodule

// File: tb/tb_potential_adder.sv
// Directed vectors for potential_adder, checked through an expected-result queue.
module tb_potential_adder;
  typedef struct packed {
    logic        clr;
    logic [1:0]  model;
    logic [31:0] thr;
    logic [31:0] dp;
    logic [31:0] iw;
    logic [31:0] c;
    logic [31:0] exp_fp;
    logic        exp_spk;
  } vec_t;

  typedef struct packed {
    logic [31:0] fp;
    logic        spk;
    int          idx;
  } exp_t;

  logic CLK;
  logic clear;
  potential_adder_if bus ();

  potential_adder dut (.CLK(CLK), .clear(clear), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  vec_t vecs[$];
  exp_t sb[$];
  int   vectors_applied = 0;
  int   miscompares = 0;
  logic issued = 1'b0;
  logic mon_done = 1'b0;

  task automatic add(input logic clr, input logic [1:0] m, input logic [31:0] thr,
                     input logic [31:0] dp, input logic [31:0] iw, input logic [31:0] c,
                     input logic [31:0] efp, input logic espk);
    vec_t v;
    v.clr = clr; v.model = m; v.thr = thr; v.dp = dp; v.iw = iw; v.c = c;
    v.exp_fp = efp; v.exp_spk = espk;
    vecs.push_back(v);
  endtask

  // Monitor: output is valid one edge after each issued vector.
  initial begin : monitor
    logic chk;
    exp_t e;
    forever begin
      @(posedge CLK);
      chk = issued;
      #1;
      if (chk) begin
        vectors_applied++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL no_expected: output seen with empty scoreboard");
        end else begin
          e = sb.pop_front();
          if (bus.final_potential !== e.fp || bus.spike !== e.spk) begin
            miscompares++;
            $display("FAIL vec%0d: got fp=%08h spike=%0b, want fp=%08h spike=%0b",
                     e.idx, bus.final_potential, bus.spike, e.fp, e.spk);
          end
        end
      end
    end
  end

  initial begin : driver
    exp_t e;
    int   idle;
    clear = 1'b0;
    bus.model = 2'b00; bus.v_threshold = 32'd0; bus.decayed_potential = 32'd0;
    bus.input_weight = 32'd0; bus.a = 32'd0; bus.b = 32'd0; bus.c = 32'd0;
    bus.d = 32'd0; bus.u_initialize = 32'd0;

    add(1'b1, 2'b00, 32'h42200000, 32'h425ED852, 32'h42470A3D, 32'h0,        32'h00000000, 1'b0);
    add(1'b0, 2'b00, 32'h42200000, 32'h425ED852, 32'h42470A3D, 32'h4287C7AE, 32'h00000000, 1'b1);
    add(1'b0, 2'b01, 32'h42200000, 32'h425ED852, 32'h42470A3D, 32'h4287C7AE, 32'h4287C7AE, 1'b1);
    add(1'b0, 2'b00, 32'h42C80000, 32'h41200000, 32'h40A00000, 32'h4287C7AE, 32'h41700000, 1'b0);
    add(1'b0, 2'b10, 32'h41200000, 32'h41200000, 32'h40A00000, 32'h4287C7AE, 32'h40A00000, 1'b1);
    add(1'b0, 2'b00, 32'h00000000, 32'h41200000, 32'hC1200000, 32'h4287C7AE, 32'h00000000, 1'b1);
    add(1'b1, 2'b00, 32'h00000000, 32'h41200000, 32'hC1200000, 32'h4287C7AE, 32'h00000000, 1'b0);
    add(1'b0, 2'b11, 32'h42200000, 32'h425ED852, 32'h42470A3D, 32'h4287C7AE, 32'h00000000, 1'b1);
    add(1'b0, 2'b01, 32'h42C80000, 32'h3FC00000, 32'hBFA00000, 32'h4287C7AE, 32'h3E800000, 1'b0);
    add(1'b0, 2'b00, 32'h42C80000, 32'h3F800000, 32'h34400000, 32'h0,        32'h3F800002, 1'b0);
    add(1'b0, 2'b00, 32'h42C80000, 32'h3F800000, 32'h33800000, 32'h0,        32'h3F800000, 1'b0);
    add(1'b0, 2'b00, 32'h00000000, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'h0,        32'hFF800000, 1'b0);
    add(1'b0, 2'b00, 32'h3F800000, 32'h00400000, 32'h00000000, 32'h0,        32'h00000000, 1'b0);
    add(1'b0, 2'b10, 32'h00000000, 32'h80400000, 32'h80000000, 32'h0,        32'h80000000, 1'b1);
    add(1'b0, 2'b10, 32'hC0400000, 32'h40400000, 32'hC0A00000, 32'h0,        32'h3F800000, 1'b1);
    add(1'b0, 2'b10, 32'hBF800000, 32'h40400000, 32'hC0A00000, 32'h0,        32'hC0000000, 1'b0);
    add(1'b0, 2'b01, 32'h40A00000, 32'h40400000, 32'h40000000, 32'h4287C7AE, 32'h4287C7AE, 1'b1);
    add(1'b0, 2'b10, 32'h40A00000, 32'h40400000, 32'h40000000, 32'h4287C7AE, 32'h00000000, 1'b1);
    add(1'b0, 2'b00, 32'h42C80000, 32'h41200000, 32'h40A00000, 32'h0,        32'h41700000, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      clear                 = vecs[i].clr;
      bus.model             = vecs[i].model;
      bus.v_threshold       = vecs[i].thr;
      bus.decayed_potential = vecs[i].dp;
      bus.input_weight      = vecs[i].iw;
      bus.c                 = vecs[i].c;
      bus.a                 = $urandom;
      bus.b                 = $urandom;
      bus.d                 = $urandom;
      bus.u_initialize      = $urandom;
      e.fp  = vecs[i].exp_fp;
      e.spk = vecs[i].exp_spk;
      e.idx = i;
      sb.push_back(e);
      issued = 1'b1;
    end
    @(negedge CLK);
    issued = 1'b0;

    idle = 0;
    while (sb.size() != 0 && idle < 20) begin
      @(negedge CLK);
      idle++;
    end
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected results never observed, want 0", sb.size());
    end
    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end
endmodule
